lcd_sequencer: RTL and testbench

- Upstream command/character source for the 4-bit LCD nibble writer on the Spartan-3E starter board.
- After reset, runs the HD44780 power-on initialisation sequence.
- Then accepts 16-character line requests and issues each byte to the writer over a begin/done handshake.
- Owns all inter-command delays that the writer does not cover.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_sequencer_if.sv | 13 +
 rtl/lcd_delay_timer.sv | 21 ++
 rtl/lcd_sequencer.sv | 154 +++++++++++++++
 tb/tb_lcd_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared states, HD44780 init constants and default cycle counts
package lcd_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT  = 3'd0,
        INIT_NIB  = 3'd1,
        INIT_CMD  = 3'd2,
        IDLE      = 3'd3,
        SET_ADDR  = 3'd4,
        CHAR      = 3'd5,
        WAIT_DONE = 3'd6,
        DELAY     = 3'd7
    } state_t;

    localparam logic [7:0] NIB_3          = 8'h03;
    localparam logic [7:0] NIB_2          = 8'h02;
    localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
    localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
    localparam logic [7:0] CMD_DISPLAY_ON = 8'h0C;
    localparam logic [7:0] CMD_CLEAR      = 8'h01;
    localparam logic [7:0] CMD_SET_ADDR0  = 8'h80;

    localparam int DEF_POWERUP_CYCLES   = 750000;
    localparam int DEF_WAIT_4100_CYCLES = 205000;
    localparam int DEF_WAIT_100_CYCLES  = 5000;
    localparam int DEF_WAIT_40_CYCLES   = 2000;
    localparam int DEF_CLEAR_CYCLES     = 82000;
    localparam int DEF_TIMEOUT_CYCLES   = 100000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// rtl/lcd_sequencer_if.sv - begin/done handshake between sequencer and nibble writer
interface lcd_sequencer_if;
    logic       oWriteBegin;
    logic [7:0] oData_BYTE;
    logic       oRS;
    logic       oNibbleOnly;
    logic       iWriteDone;

    modport master (output oWriteBegin, output oData_BYTE, output oRS, output oNibbleOnly,
                    input  iWriteDone);
    modport slave  (input  oWriteBegin, input  oData_BYTE, input  oRS, input  oNibbleOnly,
                    output iWriteDone);
endinterface

// File: rtl/lcd_delay_timer.sv
// rtl/lcd_delay_timer.sv - cycle counter; o_done is high in the i_load-th cycle after i_start
module lcd_delay_timer #(
    parameter int W = 21
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         i_start,
    input  logic [W-1:0] i_load,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    assign o_done = (r_cnt + W'(1)) >= i_load;

    always_ff @(posedge Clock) begin
        if (Reset || i_start)
            r_cnt <= '0;
        else if (!o_done)
            r_cnt <= r_cnt + W'(1);
    end
endmodule

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 power-on init then 16-char line writes over a begin/done handshake
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES   = DEF_POWERUP_CYCLES,
    parameter int WAIT_4100_CYCLES = DEF_WAIT_4100_CYCLES,
    parameter int WAIT_100_CYCLES  = DEF_WAIT_100_CYCLES,
    parameter int WAIT_40_CYCLES   = DEF_WAIT_40_CYCLES,
    parameter int CLEAR_CYCLES     = DEF_CLEAR_CYCLES,
    parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [127:0]     iPhrase,
    input  logic             iPhraseValid,
    output logic             oReady,
    output logic             oInitDone,
    lcd_sequencer_if.master  wr
);
    localparam int MAX_CYC = max_int(max_int(max_int(POWERUP_CYCLES, WAIT_4100_CYCLES),
                                             max_int(WAIT_100_CYCLES, WAIT_40_CYCLES)),
                                     max_int(CLEAR_CYCLES, TIMEOUT_CYCLES));
    localparam int CW = $clog2(MAX_CYC) + 1;

    state_t          r_state, w_next, r_phase, w_phase_nx;
    logic [3:0]      r_idx, w_idx_nx;
    logic [CW-1:0]   r_delay, w_post_delay, w_load;
    logic [127:0]    r_phrase;
    logic            r_init_done;
    logic            w_start, w_tmr_done, w_issue, w_hold;
    logic [7:0]      w_data;

    lcd_delay_timer #(.W(CW)) u_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .i_start (w_start),
        .i_load  (w_load),
        .o_done  (w_tmr_done)
    );

    // What follows the transfer currently in flight: next phase, index and post-delay.
    always_comb begin
        w_phase_nx   = r_phase;
        w_idx_nx     = r_idx + 4'd1;
        w_post_delay = CW'(WAIT_40_CYCLES);
        w_data       = 8'h00;
        case (r_phase)
            INIT_NIB: begin
                w_data = (r_idx == 4'd3) ? NIB_2 : NIB_3;
                if (r_idx == 4'd0)      w_post_delay = CW'(WAIT_4100_CYCLES);
                else if (r_idx == 4'd1) w_post_delay = CW'(WAIT_100_CYCLES);
                if (r_idx == 4'd3) begin
                    w_phase_nx = INIT_CMD;
                    w_idx_nx   = 4'd0;
                end
            end
            INIT_CMD: begin
                case (r_idx)
                    4'd0:    w_data = CMD_FUNC_SET;
                    4'd1:    w_data = CMD_ENTRY_MODE;
                    4'd2:    w_data = CMD_DISPLAY_ON;
                    default: w_data = CMD_CLEAR;
                endcase
                if (r_idx == 4'd3) begin
                    w_post_delay = CW'(CLEAR_CYCLES);
                    w_phase_nx   = IDLE;
                    w_idx_nx     = 4'd0;
                end
            end
            SET_ADDR: begin
                w_data     = CMD_SET_ADDR0;
                w_phase_nx = CHAR;
                w_idx_nx   = 4'd0;
            end
            CHAR: begin
                w_data       = r_phrase[{r_idx, 3'b000} +: 8];
                w_post_delay = '0;
                if (r_idx == 4'd15) begin
                    w_phase_nx = IDLE;
                    w_idx_nx   = 4'd0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            r_state <= PWR_WAIT;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = r_delay;
        case (r_state)
            PWR_WAIT: begin
                w_load = CW'(POWERUP_CYCLES);
                if (w_tmr_done) w_next = INIT_NIB;
            end
            INIT_NIB, INIT_CMD, SET_ADDR, CHAR: w_next = WAIT_DONE;
            WAIT_DONE: begin
                w_load = CW'(TIMEOUT_CYCLES);
                if (wr.iWriteDone)
                    w_next = (w_post_delay == '0) ? w_phase_nx : DELAY;
                else if (w_tmr_done)
                    w_next = PWR_WAIT;
            end
            DELAY: if (w_tmr_done) w_next = r_phase;
            IDLE:  if (iPhraseValid) w_next = SET_ADDR;
            default: w_next = PWR_WAIT;
        endcase
        // Every wait state is entered through a state change, so that edge restarts the timer.
        w_start = (w_next != r_state);
        w_issue = (r_state == INIT_NIB) || (r_state == INIT_CMD) ||
                  (r_state == SET_ADDR) || (r_state == CHAR);
        w_hold  = w_issue || (r_state == WAIT_DONE);
        wr.oWriteBegin = w_issue;
        wr.oData_BYTE  = w_hold ? w_data : 8'h00;
        wr.oRS         = w_hold && (r_phase == CHAR);
        wr.oNibbleOnly = w_hold && (r_phase == INIT_NIB);
        oReady         = (r_state == IDLE);
        oInitDone      = r_init_done;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_phase     <= INIT_NIB;
            r_idx       <= 4'd0;
            r_delay     <= '0;
            r_phrase    <= '0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state == IDLE && iPhraseValid) begin
                r_phrase <= iPhrase;
                r_phase  <= SET_ADDR;
                r_idx    <= 4'd0;
            end
            if (r_state == WAIT_DONE && wr.iWriteDone) begin
                r_phase <= w_phase_nx;
                r_idx   <= w_idx_nx;
                r_delay <= w_post_delay;
            end
            if (w_next == PWR_WAIT && r_state != PWR_WAIT) begin
                r_phase     <= INIT_NIB;
                r_idx       <= 4'd0;
                r_init_done <= 1'b0;
            end else if (w_next == IDLE) begin
                r_init_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// tb/tb_lcd_sequencer.sv - directed bench with a 4-cycle-ack writer model
module tb_lcd_sequencer;
    logic         Clock = 1'b0;
    logic         Reset;
    logic [127:0] iPhrase;
    logic         iPhraseValid;
    logic         oReady, oInitDone;

    lcd_sequencer_if wr();

    lcd_sequencer #(
        .POWERUP_CYCLES(20), .WAIT_4100_CYCLES(10), .WAIT_100_CYCLES(5),
        .WAIT_40_CYCLES(3), .CLEAR_CYCLES(8), .TIMEOUT_CYCLES(50)
    ) dut (
        .Clock(Clock), .Reset(Reset), .iPhrase(iPhrase), .iPhraseValid(iPhraseValid),
        .oReady(oReady), .oInitDone(oInitDone), .wr(wr)
    );

    always #5 Clock = ~Clock;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, last_done = 0, beg_cyc = 0, t_rl = 0, t_init = 0, t_ready = 0;
    bit outstanding = 0, unstable = 0, withhold = 0, prev_init = 0, prev_ready = 0;
    logic [9:0]  held;
    logic [7:0]  q_byte[$];
    bit          q_rs[$], q_nib[$];
    int          q_cyc[$], q_gap[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] entry(input int i);
        if (i < q_byte.size()) return {22'd0, q_rs[i], q_nib[i], q_byte[i]};
        return 32'hFFFF_FFFF;
    endfunction

    function automatic int gap_at(input int i);
        if (i < q_gap.size()) return q_gap[i];
        return -1;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < q_cyc.size()) return q_cyc[i];
        return -1000;
    endfunction

    function automatic logic [127:0] to_phrase(input string s);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) p[i*8 +: 8] = s[i];
        return p;
    endfunction

    task automatic clear_log();
        q_byte.delete(); q_rs.delete(); q_nib.delete(); q_cyc.delete(); q_gap.delete();
    endtask

    // One cycle: sample at the falling edge, log begins, then drive the writer ack.
    task automatic step();
        @(negedge Clock);
        cyc++;
        if (oInitDone && !prev_init) t_init = cyc;
        if (oReady && !prev_ready)   t_ready = cyc;
        prev_init  = oInitDone;
        prev_ready = oReady;
        if (wr.oWriteBegin) begin
            check_val("no_overlap", 32'(outstanding), 32'd0);
            q_byte.push_back(wr.oData_BYTE);
            q_rs.push_back(wr.oRS);
            q_nib.push_back(wr.oNibbleOnly);
            q_cyc.push_back(cyc);
            q_gap.push_back(cyc - last_done - 1);
            outstanding = 1;
            beg_cyc     = cyc;
            held        = {wr.oRS, wr.oNibbleOnly, wr.oData_BYTE};
            unstable    = 0;
        end else if (outstanding && {wr.oRS, wr.oNibbleOnly, wr.oData_BYTE} != held) begin
            unstable = 1;
        end
        if (outstanding && cyc == beg_cyc + 4 && !(withhold && held == {2'b00, 8'h06})) begin
            wr.iWriteDone = 1'b1;
            outstanding   = 0;
            last_done     = cyc;
            check_val("hold_stable", 32'(unstable), 32'd0);
        end else begin
            wr.iWriteDone = 1'b0;
        end
    endtask

    task automatic release_reset();
        Reset     = 1'b0;
        t_rl      = cyc;
        last_done = cyc - 1;
    endtask

    logic [31:0] init_exp [8] = '{32'h103, 32'h103, 32'h103, 32'h102,
                                  32'h028, 32'h006, 32'h00C, 32'h001};
    int          gap_exp  [8] = '{20, 10, 5, 3, 3, 3, 3, 3};

    initial begin
        string s_main, s_other;
        bit pulsed;
        s_main  = "HELLO SPARTAN 3E";
        s_other = "xxxxxxxxxxxxxxxx";
        Reset = 1'b1; iPhrase = '0; iPhraseValid = 1'b0; wr.iWriteDone = 1'b0;
        repeat (2) step();
        check_val("reset_outs", 32'({wr.oWriteBegin, wr.oRS, wr.oNibbleOnly, oReady, oInitDone, wr.oData_BYTE}), 32'd0);

        // Power-on initialisation
        release_reset();
        for (int k = 0; k < 2000 && !oInitDone; k++) step();
        check_val("init_done", 32'(oInitDone), 32'd1);
        check_val("init_ready", 32'(oReady), 32'd1);
        check_val("init_count", 32'(q_byte.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("init_byte%0d", i), entry(i), init_exp[i]);
            check_val($sformatf("init_gap%0d", i), 32'(gap_at(i)), 32'(gap_exp[i]));
        end
        check_val("clear_to_initdone", 32'(t_init - last_done - 1), 32'd8);

        // Line write with a busy-time phrase request and iPhrase changing mid-line
        clear_log();
        step();
        iPhrase = to_phrase(s_main);
        iPhraseValid = 1'b1;
        step();
        iPhraseValid = 1'b0;
        check_val("accept_ready_drop", 32'(oReady), 32'd0);
        pulsed = 0;
        for (int k = 0; k < 1000 && !(oReady && q_byte.size() >= 17); k++) begin
            step();
            if (q_byte.size() == 7 && !pulsed) begin
                iPhrase = to_phrase(s_other);
                iPhraseValid = 1'b1;
                pulsed = 1;
            end else begin
                iPhraseValid = 1'b0;
            end
        end
        check_val("line_ready", 32'(oReady), 32'd1);
        check_val("addr_cmd", entry(0), 32'h080);
        for (int i = 0; i < 16; i++)
            check_val($sformatf("char%0d", i), entry(i + 1), 32'h200 | {24'd0, 8'(s_main[i])});
        check_val("char0_gap", 32'(gap_at(1)), 32'd3);
        check_val("char9_gap", 32'(gap_at(10)), 32'd0);
        check_val("ready_after_last", 32'(t_ready - last_done), 32'd1);
        repeat (30) step();
        check_val("dropped_phrase", 32'(q_byte.size()), 32'd17);

        // Reset during character 9
        clear_log();
        iPhrase = to_phrase(s_main);
        iPhraseValid = 1'b1;
        step();
        iPhraseValid = 1'b0;
        for (int k = 0; k < 500 && q_byte.size() < 11; k++) step();
        check_val("char9_seen", entry(10), 32'h200 | {24'd0, 8'(s_main[9])});
        Reset = 1'b1;
        step();
        check_val("midline_reset_outs", 32'({wr.oWriteBegin, wr.oRS, wr.oNibbleOnly, oReady, oInitDone, wr.oData_BYTE}), 32'd0);
        step();
        outstanding = 0;
        clear_log();

        // Re-initialisation with the 0x06 ack withheld, then a clean rerun
        withhold = 1;
        release_reset();
        for (int k = 0; k < 1000 && q_byte.size() < 7; k++) begin
            step();
            if (q_byte.size() == 6 && cyc == cyc_at(5) + 50)
                check_val("timeout_hold", 32'(wr.oData_BYTE), 32'h06);
            if (q_byte.size() == 6 && cyc == cyc_at(5) + 51) begin
                check_val("timeout_abort", 32'({oInitDone, oReady, wr.oData_BYTE}), 32'd0);
                outstanding = 0;
                withhold    = 0;
            end
        end
        check_val("reinit_gap0", 32'(gap_at(0)), 32'd20);
        check_val("timeout_cmd", entry(5), 32'h006);
        check_val("restart_nib", entry(6), 32'h103);
        check_val("restart_delay", 32'(cyc_at(6) - cyc_at(5)), 32'd71);
        for (int k = 0; k < 2000 && !oInitDone; k++) step();
        check_val("reinit_done", 32'(oInitDone), 32'd1);
        check_val("reinit_ready", 32'(oReady), 32'd1);
        check_val("ready_with_init", 32'(t_ready - t_init), 32'd0);
        for (int i = 0; i < 8; i++)
            check_val($sformatf("reinit_byte%0d", i), entry(i + 6), init_exp[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
